// File: rtl/obf_key_pkg.sv
// obf_key_pkg: shared FSM state type, gate-mode encodings and default gate count
package obf_key_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, CHECK, LOCKED} state_t;
  localparam logic [1:0] MODE_PASS   = 2'b00;
  localparam logic [1:0] MODE_INV    = 2'b01;
  localparam logic [1:0] MODE_CONST1 = 2'b10;
  localparam logic [1:0] MODE_CONST0 = 2'b11;
  localparam int NUM_GATES_DEF = 5;
endpackage

// File: rtl/obf_key_shifter.sv
// obf_key_shifter: LSB-first shadow register, bit counter and parity flop
//   clear    - zero counter, shadow and parity
//   shift    - accept ser_data: shadow bit while count<KEY_W, parity bit when count==KEY_W
//   shadow   - partially or fully shifted key (never seen by the netlist)
//   parity   - captured even-parity bit
//   last     - count==KEY_W, next accepted bit is the parity bit
module obf_key_shifter #(
  parameter int KEY_W = 10,
  localparam int CW = $clog2(KEY_W + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             shift,
  input  logic             ser_data,
  output logic [KEY_W-1:0] shadow,
  output logic             parity,
  output logic             last
);
  logic [CW-1:0] count;
  assign last = count == CW'(KEY_W);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      shadow <= '0;
      parity <= 1'b0;
    end else if (clear) begin
      count  <= '0;
      shadow <= '0;
      parity <= 1'b0;
    end else if (shift) begin
      if (last) parity <= ser_data;
      else begin
        for (int i = 0; i < KEY_W; i++) if (count == CW'(i)) shadow[i] <= ser_data;
        count <= count + 1'b1;
      end
    end
  end
endmodule

// File: rtl/obf_key_loader.sv
// obf_key_loader: serial, parity-checked key loader with lock for an obfuscated netlist
//   load_start/ser_valid/ser_data - start request and serial key+parity stream
//   lock      - freeze committed key until reset (only in IDLE with a valid key)
//   ser_ready - high in SHIFT;  locked - high in LOCKED
//   key_out/key_valid - committed key, only updated by a good-parity CHECK
//   load_done/load_err - one-cycle registered commit / parity-failure pulses
module obf_key_loader
  import obf_key_pkg::*;
#(
  parameter int NUM_GATES = NUM_GATES_DEF,
  parameter int KEY_W = 2 * NUM_GATES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_start,
  input  logic             ser_valid,
  input  logic             ser_data,
  input  logic             lock,
  output logic             ser_ready,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  output logic             load_done,
  output logic             load_err,
  output logic             locked
);
  state_t state, next;
  logic [KEY_W-1:0] shadow;
  logic parity, last, take_lock, clear, shift, good;
  assign take_lock = lock & key_valid;
  // lock beats load_start in IDLE; load_start in SHIFT restarts and drops that cycle's bit
  assign clear = load_start & (state == SHIFT || (state == IDLE && !take_lock));
  assign shift = ser_ready & ser_valid & !load_start;
  assign good = ~(^shadow ^ parity);
  assign ser_ready = state == SHIFT;
  assign locked = state == LOCKED;
  obf_key_shifter #(.KEY_W(KEY_W)) u_shifter (
    .clk(clk), .rst_n(rst_n), .clear(clear), .shift(shift), .ser_data(ser_data),
    .shadow(shadow), .parity(parity), .last(last)
  );
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = take_lock ? LOCKED : load_start ? SHIFT : IDLE;
      SHIFT:   next = (shift && last) ? CHECK : SHIFT;
      CHECK:   next = IDLE;
      default: next = LOCKED;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      key_out   <= '0;
      key_valid <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      state     <= next;
      load_done <= state == CHECK && good;
      load_err  <= state == CHECK && !good;
      if (state == CHECK && good) begin
        key_out   <= shadow;
        key_valid <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_obf_key_loader.sv
// tb_obf_key_loader: directed + randomized self-checking bench for obf_key_loader
module tb_obf_key_loader;
  localparam int KEY_W = 10;
  logic clk = 0, rst_n = 0, load_start = 0, ser_valid = 0, ser_data = 0, lock = 0;
  logic ser_ready, key_valid, load_done, load_err, locked;
  logic [KEY_W-1:0] key_out;
  int total = 0, bad = 0;
  logic [KEY_W-1:0] exp_key = '0;
  logic exp_valid = 0, exp_locked = 0;

  obf_key_loader #(.NUM_GATES(5)) dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .ser_valid(ser_valid),
    .ser_data(ser_data), .lock(lock), .ser_ready(ser_ready), .key_out(key_out),
    .key_valid(key_valid), .load_done(load_done), .load_err(load_err), .locked(locked)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start();
    load_start = 1;
    ser_valid = 1;
    ser_data = 1'($urandom);
    tick();
    load_start = 0;
    ser_valid = 0;
  endtask

  task automatic send(input logic b, input int gapmax);
    int gap = $urandom_range(gapmax, 0);
    repeat (gap) begin
      ser_valid = 0;
      chk("ready_gap", ser_ready, !exp_locked);
      tick();
    end
    ser_valid = 1;
    ser_data = b;
    chk("ready", ser_ready, !exp_locked);
    chk("key_stable", key_out, exp_key);
    tick();
    ser_valid = 0;
  endtask

  task automatic partial(input logic [KEY_W-1:0] k, input int n);
    start();
    for (int i = 0; i < n; i++) send(k[i], 0);
  endtask

  task automatic load(input logic [KEY_W-1:0] k, input logic p, input int gapmax);
    logic good;
    start();
    for (int i = 0; i < KEY_W; i++) send(k[i], gapmax);
    send(p, gapmax);
    chk("done_early", load_done, 0);
    chk("err_early", load_err, 0);
    tick();
    good = (($countones(k) + int'(p)) % 2) == 0;
    chk("load_done", load_done, !exp_locked && good);
    chk("load_err", load_err, !exp_locked && !good);
    if (!exp_locked && good) begin
      exp_key = k;
      exp_valid = 1;
    end
    chk("key_out", key_out, exp_key);
    chk("key_valid", key_valid, exp_valid);
    chk("locked", locked, exp_locked);
    tick();
    chk("done_clear", load_done, 0);
    chk("err_clear", load_err, 0);
  endtask

  initial begin
    logic [KEY_W-1:0] rk;
    logic rp;
    tick();
    tick();
    rst_n = 1;
    repeat (10) tick();
    chk("rst_key", key_out, 0);
    chk("rst_valid", key_valid, 0);
    chk("rst_ready", ser_ready, 0);
    chk("rst_locked", locked, 0);
    chk("rst_done", load_done, 0);
    chk("rst_err", load_err, 0);
    lock = 1;
    tick();
    lock = 0;
    tick();
    chk("lock_no_key", locked, 0);
    load(10'h2D3, 1'b1, 0);
    chk("bad_par_key", key_out, 10'h000);
    load(10'h2D3, 1'b0, 0);
    chk("good_key", key_out, 10'h2D3);
    partial(10'h155, 4);
    chk("restart_hold", key_out, 10'h2D3);
    load(10'h155, 1'b1, 0);
    chk("restart_key", key_out, 10'h155);
    load(10'h2D3, 1'b0, 5);
    chk("gap_key", key_out, 10'h2D3);
    for (int n = 0; n < 8; n++) begin
      rk = KEY_W'($urandom);
      rp = 1'($urandom);
      load(rk, rp, 3);
    end
    load(10'h2D3, 1'b0, 2);
    lock = 1;
    load_start = 1;
    tick();
    lock = 0;
    load_start = 0;
    exp_locked = 1;
    chk("lock_wins", locked, 1);
    chk("lock_ready", ser_ready, 0);
    load(10'h155, 1'b1, 1);
    chk("locked_key", key_out, 10'h2D3);
    chk("locked_valid", key_valid, 1);
    rst_n = 0;
    #1;
    chk("async_key", key_out, 0);
    chk("async_valid", key_valid, 0);
    chk("async_locked", locked, 0);
    chk("async_ready", ser_ready, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
